// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce_sync block.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } db_state_e;

  localparam int GLITCH_CNT_W = 8;

endpackage

// File: rtl/sync_chain.sv
// SYNC_STAGES-deep 1-bit synchronizer; all flops reset to 0 asynchronously.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= sync_d;
  end

  assign s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizer + 4-state debounce FSM with registered level and edge pulses.
// Optional aborted-transition counter enabled by DEBOUNCE_GLITCH_CNT_EN.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic d_raw,
  output logic q_clean,
  output logic rise,
  output logic fall,
  output logic busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic s;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (d_raw),
    .s   (s)
  );

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_clean_q, q_clean_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic                    abort;
  logic [GLITCH_CNT_W-1:0] glitch_q, glitch_d;
`endif

  // Abort is tested before terminal count so a late toggle always wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_clean_d = q_clean_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    abort     = 1'b0;
`endif
    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = PEND_HI;
          cnt_d   = '0;
        end
      end
      PEND_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
`ifdef DEBOUNCE_GLITCH_CNT_EN
          abort   = 1'b1;
`endif
        end else if (cnt_q == CNT_MAX) begin
          state_d   = STABLE_HI;
          q_clean_d = 1'b1;
          rise_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = PEND_LO;
          cnt_d   = '0;
        end
      end
      PEND_LO: begin
        if (s) begin
          state_d = STABLE_HI;
`ifdef DEBOUNCE_GLITCH_CNT_EN
          abort   = 1'b1;
`endif
        end else if (cnt_q == CNT_MAX) begin
          state_d   = STABLE_LO;
          q_clean_d = 1'b0;
          fall_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == PEND_HI) || (state_d == PEND_LO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= STABLE_LO;
      cnt_q     <= '0;
      q_clean_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_clean_q <= q_clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      busy_q    <= busy_d;
    end
  end

  assign q_clean = q_clean_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign busy    = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  // Saturating count of aborted transitions.
  always_comb begin
    glitch_d = glitch_q;
    if (abort && (glitch_q != '1)) glitch_d = glitch_q + GLITCH_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) glitch_q <= '0;
    else      glitch_q <= glitch_d;
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_debounce_sync;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic d_raw = 1'b0;
  logic q_clean, rise, fall, busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .d_raw   (d_raw),
    .q_clean (q_clean),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    d_raw = 1'b1;
    tick(5);
    tests++; if ({q_clean, rise, fall, busy} !== 4'b0000) begin fails++;
      $display("FAIL reset_outs: got q/r/f/b=%b exp 0000", {q_clean, rise, fall, busy}); end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    tests++; if (glitch_cnt !== 8'd0) begin fails++;
      $display("FAIL reset_glitch: got %0d exp 0", glitch_cnt); end
`endif
    rst = 1'b1;
    tick(6);
    tests++; if ({q_clean, busy} !== 2'b01) begin fails++;
      $display("FAIL release_e6: got q/b=%b exp 01", {q_clean, busy}); end
    tick(1);
    tests++; if ({q_clean, rise, busy} !== 3'b110) begin fails++;
      $display("FAIL release_e7: got q/r/b=%b exp 110", {q_clean, rise, busy}); end
    tick(1);
    tests++; if ({q_clean, rise} !== 2'b10) begin fails++;
      $display("FAIL release_e8: got q/r=%b exp 10", {q_clean, rise}); end
  endtask

  task automatic test_clean_edges;
    d_raw = 1'b0;
    tick(6);
    tests++; if ({q_clean, fall} !== 2'b10) begin fails++;
      $display("FAIL fall1_e6: got q/f=%b exp 10", {q_clean, fall}); end
    tick(1);
    tests++; if ({q_clean, rise, fall} !== 3'b001) begin fails++;
      $display("FAIL fall1_e7: got q/r/f=%b exp 001", {q_clean, rise, fall}); end
    tick(1);
    tests++; if (fall !== 1'b0) begin fails++;
      $display("FAIL fall1_pulse: got %b exp 0", fall); end
    d_raw = 1'b1;
    tick(6);
    tests++; if ({q_clean, rise} !== 2'b00) begin fails++;
      $display("FAIL rise_e6: got q/r=%b exp 00", {q_clean, rise}); end
    tick(1);
    tests++; if ({q_clean, rise, fall} !== 3'b110) begin fails++;
      $display("FAIL rise_e7: got q/r/f=%b exp 110", {q_clean, rise, fall}); end
    tick(13);
    tests++; if ({q_clean, rise, busy} !== 3'b100) begin fails++;
      $display("FAIL rise_hold: got q/r/b=%b exp 100", {q_clean, rise, busy}); end
    d_raw = 1'b0;
    tick(7);
    tests++; if ({q_clean, rise, fall} !== 3'b001) begin fails++;
      $display("FAIL fall2_e7: got q/r/f=%b exp 001", {q_clean, rise, fall}); end
    tick(1);
    tests++; if ({q_clean, fall, busy} !== 3'b000) begin fails++;
      $display("FAIL fall2_after: got q/f/b=%b exp 000", {q_clean, fall, busy}); end
  endtask

  task automatic test_glitch_reject;
    logic seen_rise;
    seen_rise = 1'b0;
    d_raw = 1'b1;
    tick(2);
    d_raw = 1'b0;
    tick(1);
    tests++; if ({q_clean, busy} !== 2'b01) begin fails++;
      $display("FAIL glitch_busy: got q/b=%b exp 01", {q_clean, busy}); end
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen_rise = seen_rise | rise | q_clean;
    end
    tests++; if ({seen_rise, busy} !== 2'b00) begin fails++;
      $display("FAIL glitch_quiet: got rise_or_q/b=%b exp 00", {seen_rise, busy}); end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    tests++; if (glitch_cnt !== 8'd1) begin fails++;
      $display("FAIL glitch_cnt1: got %0d exp 1", glitch_cnt); end
`endif
  endtask

  task automatic test_terminal_abort;
    d_raw = 1'b1;
    tick(4);
    d_raw = 1'b0;
    tick(2);
    tests++; if ({q_clean, busy} !== 2'b01) begin fails++;
      $display("FAIL term_e6: got q/b=%b exp 01", {q_clean, busy}); end
    tick(1);
    tests++; if ({q_clean, rise, busy} !== 3'b000) begin fails++;
      $display("FAIL term_e7: got q/r/b=%b exp 000", {q_clean, rise, busy}); end
    tick(5);
    tests++; if ({q_clean, rise, busy} !== 3'b000) begin fails++;
      $display("FAIL term_after: got q/r/b=%b exp 000", {q_clean, rise, busy}); end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    tests++; if (glitch_cnt !== 8'd2) begin fails++;
      $display("FAIL term_glitch: got %0d exp 2", glitch_cnt); end
`endif
  endtask

  task automatic test_reset_mid_pend;
    d_raw = 1'b1;
    tick(7);
    tests++; if (q_clean !== 1'b1) begin fails++;
      $display("FAIL mid_setup: got q=%b exp 1", q_clean); end
    tick(3);
    d_raw = 1'b0;
    tick(4);
    tests++; if ({q_clean, busy} !== 2'b11) begin fails++;
      $display("FAIL mid_pend: got q/b=%b exp 11", {q_clean, busy}); end
    #2 rst = 1'b0;
    #1;
    tests++; if ({q_clean, rise, fall, busy} !== 4'b0000) begin fails++;
      $display("FAIL mid_async: got q/r/f/b=%b exp 0000", {q_clean, rise, fall, busy}); end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    tests++; if (glitch_cnt !== 8'd0) begin fails++;
      $display("FAIL mid_glitch: got %0d exp 0", glitch_cnt); end
`endif
    tick(2);
    rst = 1'b1;
    tick(10);
    tests++; if ({q_clean, fall, busy} !== 3'b000) begin fails++;
      $display("FAIL mid_after: got q/f/b=%b exp 000", {q_clean, fall, busy}); end
  endtask

  task automatic test_saturation;
    logic moved;
    moved = 1'b0;
    for (int i = 0; i < 300; i++) begin
      d_raw = 1'b1;
      tick(1);
      d_raw = 1'b0;
      for (int j = 0; j < 4; j++) begin
        tick(1);
        moved = moved | q_clean | rise | fall;
      end
    end
    tests++; if ({moved, busy} !== 2'b00) begin fails++;
      $display("FAIL sat_quiet: got moved/b=%b exp 00", {moved, busy}); end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    tests++; if (glitch_cnt !== 8'd255) begin fails++;
      $display("FAIL sat_cnt: got %0d exp 255", glitch_cnt); end
    d_raw = 1'b1;
    tick(1);
    d_raw = 1'b0;
    tick(6);
    tests++; if (glitch_cnt !== 8'd255) begin fails++;
      $display("FAIL sat_hold: got %0d exp 255", glitch_cnt); end
`endif
  endtask

  initial begin
    test_reset;
    test_clean_edges;
    test_glitch_reject;
    test_terminal_abort;
    test_reset_mid_pend;
    test_saturation;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
